// File: rtl/fetch_datapath_pkg.sv
// Shared definitions for the instruction fetch datapath: ALU opcodes,
// fetch FSM states and the default memory-wait timeout.
package fetch_datapath_pkg;

  // PC-update operation codes; only ADD is supported for the PC.
  localparam logic [2:0] ALU_ADD = 3'b001;

  // Default number of REQ cycles to wait for mem_ready before giving up.
  localparam int DEFAULT_TIMEOUT = 15;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_t;

endpackage : fetch_datapath_pkg

// File: rtl/fetch_datapath_pc_register.sv
// Program counter register with its +4 adder. Any PC write with an
// unsupported operation leaves the PC alone and flags bad_op for one cycle.
module pc_register
  import fetch_datapath_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCwrite,
  input  logic [2:0]  AluOperation,
  output logic [31:0] pc,
  output logic        bad_op
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Next PC: increment by 4 (wrapping naturally at 2^32) on a valid ADD write.
  always_comb begin
    pc_d   = pc_q;
    bad_op = 1'b0;
    if (PCwrite) begin
      if (AluOperation == ALU_ADD) begin
        pc_d = pc_q + 32'd4;
      end else begin
        bad_op = 1'b1;
      end
    end
  end

  // PC state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule : pc_register

// File: rtl/fetch_datapath.sv
// Instruction fetch datapath: PC register plus a three-state fetch FSM that
// issues one memory read per trigger, captures the returned word into the
// instruction register and keeps a sticky fault flag for every misuse.
module fetch_datapath
  import fetch_datapath_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCwrite,
  input  logic        IRwrite,
  input  logic [2:0]  AluOperation,
  input  logic        MemRead,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        busy,
  output logic        fault
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value on the final REQ cycle allowed before timing out.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic bad_op;
  logic trigger;

  fetch_state_t     state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk         (clk),
    .rst         (rst),
    .PCwrite     (PCwrite),
    .AluOperation(AluOperation),
    .pc          (pc),
    .bad_op      (bad_op)
  );

  // Either strobe starts a fetch; they are interchangeable.
  assign trigger = IRwrite | MemRead;

  // Fetch FSM next-state and registered-output logic. The fetch address is
  // taken from the current (pre-update) PC so a same-cycle PCwrite does not
  // affect it.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    cnt_d         = cnt_q;
    fault_d       = fault_q | bad_op;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          if (pc[1:0] == 2'b00) begin
            state_d    = ST_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = pc;
            cnt_d      = '0;
          end else begin
            fault_d = 1'b1;
          end
        end
      end

      ST_REQ: begin
        if (trigger) begin
          fault_d = 1'b1;
        end
        if (mem_ready) begin
          instr_d       = mem_rdata;
          instr_valid_d = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          fault_d   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (trigger) begin
          fault_d = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Fetch FSM state and output registers; reset drops mem_req at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 32'd0;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      cnt_q         <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      cnt_q         <= cnt_d;
      fault_q       <= fault_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign fault       = fault_q;

endmodule : fetch_datapath

// File: tb/tb_fetch_datapath.sv
// Self-checking bench for fetch_datapath: a PC-update vector table, hand
// sequences for fetch, timeout, overrun and reset-during-fetch, and a
// scoreboard queue checked on every instr_valid pulse.
module tb_fetch_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCwrite, IRwrite, MemRead, mem_ready;
  logic [2:0]  AluOperation;
  logic [31:0] mem_rdata;
  logic        mem_req, instr_valid, busy, fault;
  logic [31:0] mem_addr, pc, instr;

  // Second instance reset to the top of the address space to exercise wrap.
  logic        w_PCwrite;
  logic [2:0]  w_AluOperation;
  logic        w_IRwrite, w_MemRead, w_mem_ready;
  logic [31:0] w_mem_rdata;
  logic        w_mem_req, w_instr_valid, w_busy, w_fault;
  logic [31:0] w_mem_addr, w_pc, w_instr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        pcw;
    logic [2:0]  op;
    logic [31:0] exp_pc;
    logic        exp_fault;
  } pc_vec_t;

  pc_vec_t vecs[7];

  always #5 clk = ~clk;

  fetch_datapath #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .PCwrite(PCwrite), .IRwrite(IRwrite),
    .AluOperation(AluOperation), .MemRead(MemRead), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pc(pc), .instr(instr), .instr_valid(instr_valid), .busy(busy),
    .fault(fault)
  );

  fetch_datapath #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(15)) dut_w (
    .clk(clk), .rst(rst), .PCwrite(w_PCwrite), .IRwrite(w_IRwrite),
    .AluOperation(w_AluOperation), .MemRead(w_MemRead), .mem_req(w_mem_req),
    .mem_addr(w_mem_addr), .mem_ready(w_mem_ready), .mem_rdata(w_mem_rdata),
    .pc(w_pc), .instr(w_instr), .instr_valid(w_instr_valid), .busy(w_busy),
    .fault(w_fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard: every instr_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (instr_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: instr_valid with instr %08h, none expected", instr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (instr !== e) begin
          n_fail++;
          $display("FAIL sb_instr: got %08h expected %08h", instr, e);
        end else begin
          $display("sb: instr %08h delivered", instr);
        end
      end
    end
  end

  initial begin
    int cyc;
    rst = 1'b1;
    PCwrite = 0; IRwrite = 0; MemRead = 0; mem_ready = 0;
    AluOperation = 3'b000; mem_rdata = 32'd0;
    w_PCwrite = 0; w_IRwrite = 0; w_MemRead = 0; w_mem_ready = 0;
    w_AluOperation = 3'b000; w_mem_rdata = 32'd0;

    vecs[0] = '{1'b1, 3'b001, 32'h0000_0004, 1'b0};
    vecs[1] = '{1'b1, 3'b001, 32'h0000_0008, 1'b0};
    vecs[2] = '{1'b1, 3'b001, 32'h0000_000C, 1'b0};
    vecs[3] = '{1'b0, 3'b010, 32'h0000_000C, 1'b0};
    vecs[4] = '{1'b1, 3'b001, 32'h0000_0010, 1'b0};
    vecs[5] = '{1'b1, 3'b010, 32'h0000_0010, 1'b1};
    vecs[6] = '{1'b1, 3'b001, 32'h0000_0014, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    rst = 1'b0;
    $display("reset: pc=%08h fault=%0b", pc, fault);

    // PC update table
    for (int i = 0; i < 7; i++) begin
      PCwrite = vecs[i].pcw;
      AluOperation = vecs[i].op;
      tick();
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_fault", i), {31'd0, fault}, {31'd0, vecs[i].exp_fault});
      $display("vec%0d: PCwrite=%0b op=%03b pc=%08h fault=%0b", i, vecs[i].pcw, vecs[i].op, pc, fault);
    end
    PCwrite = 0;
    AluOperation = 3'b000;

    // Normal fetch from pc=8, mem_ready two cycles after mem_req
    do_reset();
    PCwrite = 1; AluOperation = 3'b001;
    tick(); tick();
    PCwrite = 0;
    check("fetch_pc", pc, 32'h8);
    IRwrite = 1;
    tick();
    IRwrite = 0;
    check("fetch_req", {31'd0, mem_req}, 32'd1);
    check("fetch_addr", mem_addr, 32'h8);
    check("fetch_busy", {31'd0, busy}, 32'd1);
    tick();
    check("fetch_req_hold", {31'd0, mem_req}, 32'd1);
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    mem_ready = 0; mem_rdata = 32'd0;
    check("fetch_valid", {31'd0, instr_valid}, 32'd1);
    check("fetch_instr", instr, 32'hDEAD_BEEF);
    check("fetch_req_drop", {31'd0, mem_req}, 32'd0);
    tick();
    check("fetch_valid_pulse", {31'd0, instr_valid}, 32'd0);
    check("fetch_idle", {31'd0, busy}, 32'd0);
    check("fetch_fault", {31'd0, fault}, 32'd0);
    $display("fetch: addr=8 instr=%08h", instr);

    // Timeout: mem_ready never arrives
    IRwrite = 1;
    tick();
    IRwrite = 0;
    cyc = 0;
    while (mem_req && cyc < 40) begin
      cyc++;
      tick();
    end
    check("to_req_cycles", cyc, 15);
    check("to_fault", {31'd0, fault}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_instr", instr, 32'hDEAD_BEEF);
    $display("timeout: req cycles=%0d fault=%0b", cyc, fault);

    // Overrun plus PCwrite during fetch; MemRead as first trigger
    do_reset();
    MemRead = 1; PCwrite = 1; AluOperation = 3'b001;
    tick();
    MemRead = 0; PCwrite = 0;
    check("ovr_addr_prepc", mem_addr, 32'h0);
    check("ovr_pc", pc, 32'h4);
    check("ovr_req", {31'd0, mem_req}, 32'd1);
    check("ovr_fault0", {31'd0, fault}, 32'd0);
    IRwrite = 1; PCwrite = 1;
    tick();
    IRwrite = 0; PCwrite = 0;
    check("ovr_fault", {31'd0, fault}, 32'd1);
    check("ovr_pc2", pc, 32'h8);
    check("ovr_addr_hold", mem_addr, 32'h0);
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    tick();
    mem_ready = 0;
    check("ovr_instr", instr, 32'h1234_5678);
    tick();
    check("ovr_idle", {31'd0, busy}, 32'd0);
    $display("overrun: instr=%08h fault=%0b", instr, fault);

    // Reset asserted mid-REQ
    do_reset();
    PCwrite = 1; AluOperation = 3'b001;
    tick();
    PCwrite = 0;
    IRwrite = 1;
    tick();
    IRwrite = 0;
    check("rreq_req", {31'd0, mem_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rreq_req_drop", {31'd0, mem_req}, 32'd0);
    check("rreq_pc", pc, 32'h0);
    check("rreq_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ready = 0;
    check("rreq_instr", instr, 32'h0);
    check("rreq_valid", {31'd0, instr_valid}, 32'd0);
    check("rreq_req_after", {31'd0, mem_req}, 32'd0);
    tick();
    $display("reset mid-fetch: instr=%08h mem_req=%0b", instr, mem_req);

    // PC wrap and bad op on the high-reset instance
    check("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
    w_PCwrite = 1; w_AluOperation = 3'b001;
    tick();
    check("wrap_pc", w_pc, 32'h0);
    check("wrap_fault0", {31'd0, w_fault}, 32'd0);
    w_AluOperation = 3'b010;
    tick();
    w_PCwrite = 0;
    check("badop_pc", w_pc, 32'h0);
    check("badop_fault", {31'd0, w_fault}, 32'd1);
    $display("wrap: pc=%08h fault=%0b", w_pc, w_fault);

    tick();
    check("sb_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_datapath

// File: doc/fetch_datapath.md
FETCH_DATAPATH -- requirements
Module: fetch_datapath

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: TIMEOUT, 15, maximum REQ-state cycles waiting for mem_ready.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 PCwrite  input  1  control strobe: update PC this cycle.
REQ-007 IRwrite  input  1  control strobe: start instruction fetch at current PC.
REQ-008 AluOperation  input  3  PC-update operation; 3'b001 = ADD.
REQ-009 MemRead  input  1  control strobe: alternate fetch trigger, identical effect to IRwrite.
REQ-010 mem_req  output  1  memory read request, registered.
REQ-011 mem_addr  output  32  read address, stable while mem_req=1.
REQ-012 mem_ready  input  1  memory response valid; mem_rdata sampled this cycle.
REQ-013 mem_rdata  input  32  memory read data.
REQ-014 pc  output  32  current program counter.
REQ-015 instr  output  32  instruction register.
REQ-016 instr_valid  output  1  one-cycle pulse: instr updated.
REQ-017 busy  output  1  high whenever FSM is not IDLE.
REQ-018 fault  output  1  sticky error flag (timeout, misalign, bad op, overrun).

Function
REQ-019 FSM states SHALL be IDLE, REQ, DONE.
REQ-020 IDLE: (IRwrite|MemRead)=1 with pc[1:0]=0 -> latch mem_addr=pc, go REQ; with pc[1:0]!=0 -> set fault, stay IDLE, no request.
REQ-021 REQ: mem_req=1; mem_ready=1 -> instr<=mem_rdata, go DONE; else timeout counter increments.
REQ-022 REQ: counter reaching TIMEOUT without mem_ready -> set fault, drop mem_req, go IDLE, instr unchanged.
REQ-023 DONE: instr_valid=1 for exactly one cycle, mem_req=0, go IDLE.
REQ-024 Latency: trigger at cycle n -> mem_req=1 at n+1; mem_ready at n+k -> instr_valid at n+k+1.
REQ-025 PCwrite=1 with AluOperation=ADD SHALL set pc<=pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-026 PCwrite=1 with any other AluOperation SHALL leave pc unchanged and set fault.
REQ-027 PCwrite SHALL act in any FSM state; in-flight mem_addr is unaffected.
REQ-028 Trigger in REQ or DONE (overrun) SHALL be ignored and set fault.
REQ-029 PCwrite and trigger in the same IDLE cycle: fetch uses pre-update pc.
REQ-030 Timeout counter SHALL clear on every entry to REQ.
REQ-031 fault SHALL clear only on reset.

Reset
REQ-032 On rst: pc=RESET_PC, instr=0, instr_valid=0, mem_req=0, mem_addr=0, busy=0, fault=0, FSM=IDLE, counter=0.
REQ-033 Reset mid-fetch SHALL drop mem_req immediately (asynchronously); late mem_ready after reset SHALL be ignored.

Structure
REQ-034 Shared package SHALL hold ALU op constants (ADD=3'b001), FSM state enum, default TIMEOUT.
REQ-035 PC register plus adder SHALL be a sub-module named pc_register (inputs PCwrite, AluOperation; outputs pc, bad_op).

Verification
REQ-036 Reset, PCwrite+ADD three cycles -> pc=0x0000_000C, fault=0.
REQ-037 pc=0x0000_0008, IRwrite, mem_ready two cycles after mem_req with rdata=0xDEAD_BEEF -> mem_addr=0x8, instr=0xDEAD_BEEF, single instr_valid pulse.
REQ-038 IRwrite, mem_ready never asserted -> mem_req drops after 15 REQ cycles, fault=1, busy=0, instr unchanged.
REQ-039 pc=0xFFFF_FFFC, PCwrite+ADD -> pc=0; then PCwrite with AluOperation=3'b010 -> pc=0, fault=1.
REQ-040 Second IRwrite while busy -> ignored, fault=1; first fetch completes normally.
REQ-041 rst asserted during REQ -> mem_req=0 same cycle, pc=RESET_PC; mem_ready afterward leaves instr=0, instr_valid=0.
